// File: rtl/mod_memmgr_if.sv
// Request/complete handshake and write-data view between the hash controller and mod_memmgr.
interface mod_memmgr_if;
    logic        copy_rom;
    logic        copy_rom_complete;
    logic [31:0] data;

    modport master (
        output copy_rom,
        input  copy_rom_complete,
        input  data
    );

    modport slave (
        input  copy_rom,
        output copy_rom_complete,
        output data
    );
endinterface

// File: rtl/mod_memmgr.sv
// Copies the SHA-256 IV/round-constant ROM into a 128-word byte-banked working RAM.
// Optional MEMMGR_CLEAR_EN: also zero RAM words 72..127 before signalling completion.
module mod_memmgr (
    input  logic         clk_i,
    input  logic         rst_ni,
    mod_memmgr_if.slave  bus
);

    localparam int unsigned RomDepth = 72;

`ifdef MEMMGR_CLEAR_EN
    localparam logic [6:0] LastAddr = 7'd127;
`else
    localparam logic [6:0] LastAddr = 7'd71;
`endif

    // H0..H7 followed by K[0]..K[63].
    localparam logic [31:0] Rom [RomDepth] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

    state_e      state_q;
    logic [6:0]  counter_q;
    logic        complete_q;
    logic [31:0] data_q;
    logic        wr_en;
    logic [31:0] wr_word;

    always_comb begin
        wr_en = (state_q == StCopy);
`ifdef MEMMGR_CLEAR_EN
        wr_word = (counter_q < 7'(RomDepth)) ? Rom[counter_q] : 32'h0;
`else
        wr_word = Rom[counter_q];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            counter_q  <= 7'd0;
            complete_q <= 1'b0;
            data_q     <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    counter_q  <= 7'd0;
                    complete_q <= 1'b0;
                    if (bus.copy_rom) begin
                        state_q <= StCopy;
                    end
                end
                StCopy: begin
                    data_q <= wr_word;
                    // Park the counter at 0 on the last write so it never wraps.
                    if (counter_q == LastAddr) begin
                        counter_q  <= 7'd0;
                        complete_q <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        counter_q <= counter_q + 7'd1;
                    end
                end
                StDone: begin
                    complete_q <= 1'b1;
                    if (!bus.copy_rom) begin
                        complete_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.copy_rom_complete = complete_q;
    assign bus.data              = data_q;

    // Working RAM: four byte lanes, bank_1 carries the most significant byte. Never reset.
    if (1'b1) begin : ram
        if (1'b1) begin : bank_1
            logic [7:0] buffer [0:127];
            always_ff @(posedge clk_i) begin
                if (wr_en) buffer[counter_q] <= wr_word[31:24];
            end
        end
        if (1'b1) begin : bank_2
            logic [7:0] buffer [0:127];
            always_ff @(posedge clk_i) begin
                if (wr_en) buffer[counter_q] <= wr_word[23:16];
            end
        end
        if (1'b1) begin : bank_3
            logic [7:0] buffer [0:127];
            always_ff @(posedge clk_i) begin
                if (wr_en) buffer[counter_q] <= wr_word[15:8];
            end
        end
        if (1'b1) begin : bank_4
            logic [7:0] buffer [0:127];
            always_ff @(posedge clk_i) begin
                if (wr_en) buffer[counter_q] <= wr_word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mod_memmgr.sv
// Self-checking bench for mod_memmgr: DATA scoreboard, RAM table checks and corner sequences.
module tb_mod_memmgr;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

`ifdef MEMMGR_CLEAR_EN
    localparam int          NWords   = 128;
    localparam logic [31:0] LastData = 32'h0;
    localparam logic [31:0] Addr100  = 32'h0;
`else
    localparam int          NWords   = 72;
    localparam logic [31:0] LastData = 32'hc67178f2;
    localparam logic [31:0] Addr100  = 32'hdeadbeef;
`endif
    localparam logic [31:0] Marker = 32'ha5a5a5a5;

    logic [31:0] rom [0:71] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        string       name;
        int          addr;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] exp_q [$];

    mod_memmgr_if bus ();

    mod_memmgr dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {dut.ram.bank_1.buffer[a], dut.ram.bank_2.buffer[a],
                dut.ram.bank_3.buffer[a], dut.ram.bank_4.buffer[a]};
    endfunction

    task automatic ram_poke(input int a, input logic [31:0] w);
        dut.ram.bank_1.buffer[a] = w[31:24];
        dut.ram.bank_2.buffer[a] = w[23:16];
        dut.ram.bank_3.buffer[a] = w[15:8];
        dut.ram.bank_4.buffer[a] = w[7:0];
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge after the edge that sampled COPY_ROM high; counts edges to COMPLETE.
    task automatic wait_complete(input int start, output int cycles);
        cycles = start;
        while (bus.copy_rom_complete !== 1'b1 && cycles < 300) begin
            cycle();
            cycles++;
        end
    endtask

    task automatic check_rom_region(input string name);
        int errs;
        errs = 0;
        for (int a = 0; a < 72; a++) begin
            if (ram_word(a) !== rom[a]) errs++;
        end
        check(name, 32'(errs), 32'd0);
    endtask

    initial begin
        int cycles;
        logic [31:0] exp;

        total = 0;
        bad   = 0;
        vecs[0] = '{name: "ram_w0",   addr: 0,   word: 32'h6a09e667};
        vecs[1] = '{name: "ram_w7",   addr: 7,   word: 32'h5be0cd19};
        vecs[2] = '{name: "ram_w8",   addr: 8,   word: 32'h428a2f98};
        vecs[3] = '{name: "ram_w71",  addr: 71,  word: 32'hc67178f2};
        vecs[4] = '{name: "ram_w100", addr: 100, word: Addr100};

        rst_n        = 1'b0;
        bus.copy_rom = 1'b0;
        ram_poke(100, 32'hdeadbeef);
        repeat (3) @(negedge clk);
        check("rst_complete", {31'd0, bus.copy_rom_complete}, 32'd0);
        check("rst_data", bus.data, 32'h0);
        rst_n = 1'b1;
        cycle();
        check("idle_no_req", {31'd0, bus.copy_rom_complete}, 32'd0);

        // Full copy with DATA scoreboard; COMPLETE must rise on exactly the last write edge.
        bus.copy_rom = 1'b1;
        for (int i = 0; i < NWords; i++) exp_q.push_back(i < 72 ? rom[i] : 32'h0);
        @(posedge clk);
        for (int i = 0; i < NWords; i++) begin
            cycle();
            exp = exp_q.pop_front();
            check($sformatf("data_w%0d", i), bus.data, exp);
            if (i == NWords - 2) check("complete_early", {31'd0, bus.copy_rom_complete}, 32'd0);
            if (i == NWords - 1) check("complete_at_last", {31'd0, bus.copy_rom_complete}, 32'd1);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        foreach (vecs[v]) check(vecs[v].name, ram_word(vecs[v].addr), vecs[v].word);
        check_rom_region("ram_all72");

        // Held request after completion: no re-copy, COMPLETE stays high.
        ram_poke(5, 32'h12345678);
        repeat (5) cycle();
        check("hold_no_rewrite", ram_word(5), 32'h12345678);
        check("hold_complete", {31'd0, bus.copy_rom_complete}, 32'd1);
        check("hold_data", bus.data, LastData);
        bus.copy_rom = 1'b0;
        cycle();
        check("complete_fall", {31'd0, bus.copy_rom_complete}, 32'd0);

        // Request dropped at cycle 10 of the copy: the copy still finishes.
        cycle();
        bus.copy_rom = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (10) cycle();
        bus.copy_rom = 1'b0;
        wait_complete(10, cycles);
        check("drop_latency", 32'(cycles), 32'(NWords));
        check("drop_restored_w5", ram_word(5), rom[5]);
        cycle();
        check("drop_complete_pulse", {31'd0, bus.copy_rom_complete}, 32'd0);
        cycle();
        check("drop_no_restart", {31'd0, bus.copy_rom_complete}, 32'd0);

        // Reset at cycle 20 of the copy: words 0..19 written, 20.. untouched.
        for (int a = 0; a < 72; a++) ram_poke(a, Marker);
        bus.copy_rom = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (20) cycle();
        rst_n = 1'b0;
        #1;
        check("abort_complete", {31'd0, bus.copy_rom_complete}, 32'd0);
        check("abort_data", bus.data, 32'h0);
        check("abort_w0", ram_word(0), rom[0]);
        check("abort_w19", ram_word(19), rom[19]);
        check("abort_w20_untouched", ram_word(20), Marker);
        check("abort_w71_untouched", ram_word(71), Marker);
        @(negedge clk);
        check("abort_held_w20", ram_word(20), Marker);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_complete(0, cycles);
        check("restart_latency", 32'(cycles), 32'(NWords));
        check_rom_region("restart_all72");
        check("restart_w100", ram_word(100), Addr100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
